// File: rtl/sm_feeder_v2_if.sv
// rtl/sm_feeder_v2_if.sv - record load, lane request, result and status signals of the target feeder
interface sm_feeder_v2_if #(
  parameter int ID_WIDTH  = 48,
  parameter int IN_WIDTH  = 316,
  parameter int CNT_WIDTH = 3
);
  logic                 ld;
  logic [IN_WIDTH-1:0]  feed_in;
  logic                 toggle;
  logic                 re0;
  logic                 re1;
  logic                 en0;
  logic                 en1;
  logic [1:0]           data_out;
  logic                 full;
  logic [CNT_WIDTH-1:0] count;
  logic [ID_WIDTH-1:0]  id0;
  logic [ID_WIDTH-1:0]  id1;
  logic                 id0_empty;
  logic                 id1_empty;
  logic                 busy;
  logic [1:0]           err;

  // Producer / scoring-array side
  modport master (
    output ld, feed_in, toggle, re0, re1,
    input  en0, en1, data_out, full, count, id0, id1, id0_empty, id1_empty, busy, err
  );

  // Feeder side
  modport slave (
    input  ld, feed_in, toggle, re0, re1,
    output en0, en1, data_out, full, count, id0, id1, id0_empty, id1_empty, busy, err
  );
endinterface

// File: rtl/sm_feeder_v2.sv
// rtl/sm_feeder_v2.sv - buffered two-lane target feeder that serialises 2-bit bases and tracks per-lane IDs
module sm_feeder_v2 #(
  parameter int TARGET_LENGTH = 128,
  parameter int LEN_WIDTH     = 12,
  parameter int ID_WIDTH      = 48,
  parameter int DEPTH         = 4,
  parameter int ID_DEPTH      = 4,
  parameter int IN_WIDTH      = ID_WIDTH + LEN_WIDTH + 2*TARGET_LENGTH
) (
  input  logic          clk,
  input  logic          rst,
  sm_feeder_v2_if.slave bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int IAW = $clog2(ID_DEPTH);
  localparam int ICW = IAW + 1;
  localparam int LW  = $clog2(TARGET_LENGTH + 1);
  localparam int BW  = 2*TARGET_LENGTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_GAP} state_t;

  // ---------------- record buffer ----------------
  logic [IN_WIDTH-1:0] rec_mem_q [DEPTH];
  logic [AW-1:0]       rec_wr_q, rec_rd_q;
  logic [CW-1:0]       count_q, count_d;
  logic                full_q;
  logic                rec_push, rec_pop;

  logic [IN_WIDTH-1:0]  head;
  logic [ID_WIDTH-1:0]  head_id;
  logic [LEN_WIDTH-1:0] head_len;
  logic [BW-1:0]        head_bases;

  assign rec_push   = bus.ld && !full_q;
  assign head       = rec_mem_q[rec_rd_q];
  assign head_id    = head[IN_WIDTH-1 -: ID_WIDTH];
  assign head_len   = head[BW +: LEN_WIDTH];
  assign head_bases = head[BW-1:0];

  // Occupancy next-state: a same-cycle push and pop cancel out
  always_comb begin
    count_d = count_q;
    case ({rec_push, rec_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Record storage; stale contents are harmless because the pointers are reset
  always_ff @(posedge clk) begin
    if (rst && rec_push) rec_mem_q[rec_wr_q] <= bus.feed_in;
  end

  // Buffer pointers, occupancy and registered full flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      rec_wr_q <= '0;
      rec_rd_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (rec_push) rec_wr_q <= rec_wr_q + AW'(1);
      if (rec_pop)  rec_rd_q <= rec_rd_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  // ---------------- sequencer ----------------
  state_t              state_q, state_d;
  logic                lane_q, lane_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW-1:0]       b_q, b_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [BW-1:0]       bases_q, bases_d;
  logic [1:0]          data_q, data_d;
  logic [1:0]          err_q;
  logic                clamp;
  logic                id_push;
  logic [1:0]          id_full, id_empty, re_bad, re_in;
  logic [ID_WIDTH-1:0] id_head [2];

  assign re_in = {bus.re1, bus.re0};

  // Next state and datapath: IDLE picks a record for the requested lane, LOAD files
  // its ID, STREAM walks the bases, GAP is the end-of-sequence marker cycle.
  // data_q is loaded one cycle ahead so it shows base b while b is current and
  // keeps the last base once streaming stops.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    len_d   = len_q;
    b_d     = b_q;
    id_d    = id_q;
    bases_d = bases_q;
    data_d  = data_q;
    rec_pop = 1'b0;
    id_push = 1'b0;
    clamp   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0 && !id_full[bus.toggle]) begin
          rec_pop = 1'b1;
          lane_d  = bus.toggle;
          id_d    = head_id;
          bases_d = head_bases;
          if (head_len > LEN_WIDTH'(TARGET_LENGTH)) begin
            clamp = 1'b1;
            len_d = LW'(TARGET_LENGTH);
          end else begin
            len_d = head_len[LW-1:0];
          end
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (len_q == '0) begin
          state_d = S_IDLE;
        end else begin
          id_push = 1'b1;
          b_d     = '0;
          data_d  = bases_q[1:0];
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (b_q == len_q - LW'(1)) begin
          state_d = S_GAP;
        end else begin
          b_d    = b_q + LW'(1);
          data_d = bases_q[2*(32'(b_q) + 1) +: 2];
        end
      end
      S_GAP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lane_q  <= 1'b0;
      len_q   <= '0;
      b_q     <= '0;
      id_q    <= '0;
      bases_q <= '0;
      data_q  <= 2'b00;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      len_q   <= len_d;
      b_q     <= b_d;
      id_q    <= id_d;
      bases_q <= bases_d;
      data_q  <= data_d;
      err_q   <= err_q | {|re_bad, clamp};
    end
  end

  // ---------------- per-lane ID FIFOs (first-word fall-through) ----------------
  for (genvar g = 0; g < 2; g++) begin : g_idf
    logic [ID_WIDTH-1:0] mem_q [ID_DEPTH];
    logic [IAW-1:0]      wr_q, rd_q;
    logic [ICW-1:0]      cnt_q;
    logic                push, pop;

    assign push        = id_push && (lane_q == 1'(g));
    assign pop         = re_in[g] && (cnt_q != '0);
    assign re_bad[g]   = re_in[g] && (cnt_q == '0);
    assign id_full[g]  = (cnt_q == ICW'(ID_DEPTH));
    assign id_empty[g] = (cnt_q == '0);
    assign id_head[g]  = mem_q[rd_q];

    // ID storage; the sequencer never pushes into a full lane
    always_ff @(posedge clk) begin
      if (rst && push) mem_q[wr_q] <= id_q;
    end

    // Lane pointers and occupancy; push and pop in one cycle both apply
    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + IAW'(1);
        if (pop)  rd_q <= rd_q + IAW'(1);
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + ICW'(1);
          2'b01:   cnt_q <= cnt_q - ICW'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.en0       = (state_q == S_STREAM) && !lane_q;
  assign bus.en1       = (state_q == S_STREAM) &&  lane_q;
  assign bus.data_out  = data_q;
  assign bus.full      = full_q;
  assign bus.count     = count_q;
  assign bus.id0       = id_head[0];
  assign bus.id1       = id_head[1];
  assign bus.id0_empty = id_empty[0];
  assign bus.id1_empty = id_empty[1];
  assign bus.busy      = (state_q != S_IDLE) || (count_q != '0);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_sm_feeder_v2.sv
// tb/tb_sm_feeder_v2.sv - directed scoreboard bench for sm_feeder_v2
module tb_sm_feeder_v2;
  localparam int TL  = 128;
  localparam int IDW = 48;
  localparam int LENW = 12;
  localparam int INW = IDW + LENW + 2*TL;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sm_feeder_v2_if #(.ID_WIDTH(IDW), .IN_WIDTH(INW), .CNT_WIDTH(3)) bus ();

  sm_feeder_v2 dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_en_cyc = -1;
  int en_seen = 0;
  bit en_prev = 1'b0;
  logic [2:0]     sb_q [$];
  logic [IDW-1:0] idq0 [$];
  logic [IDW-1:0] idq1 [$];
  int             gaps [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit later and score any streamed base
  task automatic tick();
    logic [2:0] exp;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.en0 || bus.en1) begin
      check("en_exclusive", 64'(bus.en0 & bus.en1), 64'd0);
      if (!en_prev && last_en_cyc >= 0) gaps.push_back(cyc - last_en_cyc);
      last_en_cyc = cyc;
      en_seen++;
      check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        check("stream_lane_base", 64'({bus.en1, bus.data_out}), 64'(exp));
      end
    end
    en_prev = bus.en0 || bus.en1;
  endtask

  task automatic load(input logic [IDW-1:0] id, input int len, input bit lane,
                      input bit accept, input logic [2*TL-1:0] bases_in, input bit rnd);
    logic [2*TL-1:0] bases;
    int eff;
    bases = bases_in;
    if (rnd) for (int w = 0; w < 2*TL/32; w++) bases[w*32 +: 32] = $urandom;
    bus.feed_in = {id, LENW'(len), bases};
    bus.ld = 1'b1;
    if (accept) begin
      eff = (len > TL) ? TL : len;
      for (int i = 0; i < eff; i++) sb_q.push_back({lane, bases[2*i +: 2]});
      if (eff > 0) begin
        if (lane) idq1.push_back(id);
        else      idq0.push_back(id);
      end
    end
    tick();
    bus.ld = 1'b0;
  endtask

  task automatic pop_id(input bit lane);
    logic [IDW-1:0] exp;
    if (!lane) begin
      exp = (idq0.size() != 0) ? idq0.pop_front() : '1;
      check("id0_nonempty", 64'(bus.id0_empty), 64'd0);
      check("id0_value", 64'(bus.id0), 64'(exp));
      bus.re0 = 1'b1;
    end else begin
      exp = (idq1.size() != 0) ? idq1.pop_front() : '1;
      check("id1_nonempty", 64'(bus.id1_empty), 64'd0);
      check("id1_value", 64'(bus.id1), 64'(exp));
      bus.re1 = 1'b1;
    end
    tick();
    bus.re0 = 1'b0;
    bus.re1 = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((bus.busy || sb_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(bus.busy || sb_q.size() != 0), 64'd0);
  endtask

  initial begin
    int base_en, n;
    bit seen;
    bus.ld = 1'b0; bus.feed_in = '0; bus.toggle = 1'b0; bus.re0 = 1'b0; bus.re1 = 1'b0;

    // ---- reset state ----
    rst = 1'b0;
    tick(); tick();
    check("rst_en", 64'({bus.en0, bus.en1}), 64'd0);
    check("rst_data", 64'(bus.data_out), 64'd0);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_empty", 64'({bus.id0_empty, bus.id1_empty}), 64'd3);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    rst = 1'b1;
    tick();

    // ---- single record ID=7, bases 10,01,11,00 on lane 0 ----
    bus.toggle = 1'b0;
    load(48'd7, 4, 1'b0, 1'b1, 256'h36, 1'b0);
    check("t1_count_after_ld", 64'(bus.count), 64'd1);
    check("t1_no_en_t", 64'({bus.en0, bus.en1}), 64'd0);
    tick();
    check("t1_no_en_load", 64'({bus.en0, bus.en1}), 64'd0);
    check("t1_busy_load", 64'(bus.busy), 64'd1);
    tick();
    check("t1_en0_first", 64'({bus.en0, bus.en1}), 64'd2);
    check("t1_data_first", 64'(bus.data_out), 64'd2);
    wait_idle("t1_idle", 20);
    check("t1_data_hold", 64'(bus.data_out), 64'd0);
    check("t1_id1_empty", 64'(bus.id1_empty), 64'd1);
    pop_id(1'b0);
    check("t1_id0_empty_after_re", 64'(bus.id0_empty), 64'd1);

    // ---- alternating lanes, IDs 1,2,3 of length 3 ----
    gaps.delete();
    load(48'd1, 3, 1'b0, 1'b1, '0, 1'b1);
    load(48'd2, 3, 1'b1, 1'b1, '0, 1'b1);
    load(48'd3, 3, 1'b0, 1'b1, '0, 1'b1);
    bus.toggle = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      tick();
      seen = bus.en1;
      n++;
    end
    check("t2_lane1_started", 64'(seen), 64'd1);
    bus.toggle = 1'b0;
    wait_idle("t2_idle", 40);
    check("t2_gap_count", 64'(gaps.size()), 64'd3);
    if (gaps.size() >= 3) begin
      check("t2_gap_1_2", 64'(gaps[1]), 64'd4);
      check("t2_gap_2_3", 64'(gaps[2]), 64'd4);
    end
    pop_id(1'b0);
    pop_id(1'b0);
    pop_id(1'b1);
    check("t2_all_empty", 64'({bus.id0_empty, bus.id1_empty}), 64'd3);

    // ---- zero-length record skipped ----
    load(48'd20, 0, 1'b0, 1'b1, '0, 1'b1);
    load(48'd21, 2, 1'b0, 1'b1, '0, 1'b1);
    wait_idle("t3_idle", 30);
    check("t3_id1_empty", 64'(bus.id1_empty), 64'd1);
    pop_id(1'b0);
    check("t3_id0_empty", 64'(bus.id0_empty), 64'd1);

    // ---- over-length record clamped to TARGET_LENGTH ----
    bus.toggle = 1'b1;
    check("t4_err_before", 64'(bus.err), 64'd0);
    load(48'd30, 200, 1'b1, 1'b1, '0, 1'b1);
    wait_idle("t4_idle", 200);
    check("t4_err_clamp", 64'(bus.err), 64'd1);
    pop_id(1'b1);

    // ---- back-pressure and full buffer ----
    bus.toggle = 1'b0;
    for (int i = 0; i < 4; i++) load(48'(40 + i), 1, 1'b0, 1'b1, '0, 1'b1);
    wait_idle("t5_fill0", 40);
    bus.toggle = 1'b1;
    for (int i = 0; i < 4; i++) load(48'(44 + i), 1, 1'b1, 1'b1, '0, 1'b1);
    wait_idle("t5_fill1", 40);
    bus.toggle = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load(48'(50 + i), 2, 1'b0, 1'b1, '0, 1'b1);
      check("t5_count", 64'(bus.count), 64'(i + 1));
      check("t5_full", 64'(bus.full), 64'(i == 3));
    end
    load(48'd54, 2, 1'b0, 1'b0, '0, 1'b1);
    check("t5_count_5th_ignored", 64'(bus.count), 64'd4);
    check("t5_full_held", 64'(bus.full), 64'd1);
    base_en = en_seen;
    for (int i = 0; i < 5; i++) tick();
    check("t5_stalled_no_en", 64'(en_seen - base_en), 64'd0);
    check("t5_stalled_busy", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 4; i++) pop_id(1'b0);
    wait_idle("t5_drain", 60);
    for (int i = 0; i < 4; i++) pop_id(1'b0);
    for (int i = 0; i < 4; i++) pop_id(1'b1);
    check("t5_all_empty", 64'({bus.id0_empty, bus.id1_empty}), 64'd3);
    check("t5_err_sticky", 64'(bus.err), 64'd1);

    // ---- reset during STREAM at base 5 ----
    bus.toggle = 1'b0;
    base_en = en_seen;
    load(48'd60, 10, 1'b0, 1'b1, '0, 1'b1);
    load(48'd61, 3, 1'b0, 1'b1, '0, 1'b1);
    n = 0;
    while ((en_seen - base_en) < 6 && n < 40) begin
      tick();
      n++;
    end
    check("t6_reached_base5", 64'(en_seen - base_en), 64'd6);
    rst = 1'b0;
    tick();
    sb_q.delete();
    idq0.delete();
    idq1.delete();
    check("t6_en_off", 64'({bus.en0, bus.en1}), 64'd0);
    check("t6_count", 64'(bus.count), 64'd0);
    check("t6_full", 64'(bus.full), 64'd0);
    check("t6_id_empty", 64'({bus.id0_empty, bus.id1_empty}), 64'd3);
    check("t6_busy", 64'(bus.busy), 64'd0);
    check("t6_err_cleared", 64'(bus.err), 64'd0);
    rst = 1'b1;
    bus.re1 = 1'b1;
    tick();
    bus.re1 = 1'b0;
    check("t6_err_empty_re", 64'(bus.err), 64'd2);
    base_en = en_seen;
    for (int i = 0; i < 5; i++) tick();
    check("t6_no_stream_after_rst", 64'(en_seen - base_en), 64'd0);
    check("t6_id1_still_empty", 64'(bus.id1_empty), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
